m_axis_kernel_serializer: RTL and testbench
===========================================

Name: m_axis_kernel_serializer

Overview:
- Parametrised successor to the single-pixel remapper output stage.
- Accepts fully remapped image kernels from the remapper core and serialises them onto an AXI4-Stream video master.
- Emits PIXELS_PER_BEAT pixels per beat, honours m_axis_tready backpressure, and frames the stream with tuser/tlast.
- Uses a one-kernel buffer, so upstream can remap the next kernel while the current one drains. Sits between the remapper core and the VDMA/video-out interconnect.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- KERNEL_SIZE, 64, pixels per remapped kernel. Must be a multiple of PIXELS_PER_BEAT.
- PIXELS_PER_BEAT, 1, pixels per AXIS beat. Must divide KERNEL_SIZE and IMG_WIDTH.
- IMG_WIDTH, 4096, pixels per line. Must be a multiple of KERNEL_SIZE.
- IMG_HEIGHT, 3072, lines per frame.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_aresetn  in  1  reset: asynchronous, active-low.
- i_image_kernel_remapped  in  KERNEL_SIZE x DATA_WIDTH  kernel pixels, index 0 transmitted first.
- i_kernel_valid  in  1  kernel on i_image_kernel_remapped is complete.
- o_kernel_ready  out  1  block captures the kernel this cycle if i_kernel_valid=1.
- m_axis_tdata  out  PIXELS_PER_BEAT*DATA_WIDTH  pixel k of the beat is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tuser  out  1  start of frame; asserted on first beat only.
- m_axis_tlast  out  1  end of line; asserted on last beat of each line.
- o_frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- o_underrun  out  1  sticky flag: buffer ran empty mid-line. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0, o_kernel_ready 0 during reset. Buffer empty, beat_idx=0, x=0, y=0, state=IDLE.
- Derived constants: BEATS_PER_KERNEL = KERNEL_SIZE/PIXELS_PER_BEAT; BEATS_PER_LINE = IMG_WIDTH/PIXELS_PER_BEAT. Counter widths are $clog2 of each, minimum 1.
- Kernel buffer:
  - Registered copy of the input kernel plus buf_valid.
  - Capture on i_kernel_valid & o_kernel_ready.
  - o_kernel_ready = ~buf_valid | (out_load & beat_idx==BEATS_PER_KERNEL-1). Combinational, so back-to-back kernels stream with no bubble.
- Output register:
  - out_load = buf_valid & (~m_axis_tvalid | m_axis_tready).
  - On out_load: tdata = buffer beat beat_idx; tvalid=1; tuser/tlast from counters; beat_idx increments and wraps at BEATS_PER_KERNEL-1, where buf_valid clears unless a new kernel is captured the same cycle.
  - While tvalid & ~tready, tdata/tuser/tlast are held stable.
  - If tready=1 and nothing loads, tvalid drops to 0.
- Latency: kernel captured at cycle N -> first beat valid at N+1.
- Position counters advance on out_load, not on handshake:
  - x_beat wraps at BEATS_PER_LINE-1 and increments y; y wraps at IMG_HEIGHT-1.
  - tuser = (x_beat==0 & y==0). tlast = (x_beat==BEATS_PER_LINE-1).
- State machine (typedef statetype):
  - IDLE: waiting for first kernel of a frame. On out_load -> STREAM.
  - STREAM: loading beats. Buffer empty with x_beat!=0 -> STARVED, set o_underrun. Last beat of frame loaded -> DRAIN.
  - STARVED: tvalid deasserts once the held beat is accepted. Kernel arrives -> STREAM.
  - DRAIN: wait for handshake of the final beat, then pulse o_frame_done next cycle -> IDLE. Kernel capture is still allowed in DRAIN, so the next frame can preload.
  - Buffer empty at a line boundary (x_beat==0, mid-frame) is not an underrun; stay in STREAM.
- Simultaneous capture and last-beat load: new kernel overwrites the buffer; beat_idx restarts at 0; no beat lost.
- Reset mid-frame: everything returns to reset values asynchronously. The next frame starts with tuser.
- i_kernel_valid may drop without a handshake. The kernel is only sampled on handshake.

Decomposition:
- Shared package remapper_pkg holds:
  - statetype enum {IDLE, STREAM, STARVED, DRAIN};
  - functions beats_per_kernel() and beats_per_line();
  - localparam checks, with $error on non-divisible parameters.
- One natural sub-module: kernel_beat_buffer. It owns the buffer register, buf_valid, beat_idx, o_kernel_ready and beat selection. The top owns the output register, counters and FSM.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=2, KERNEL_SIZE=4, PIXELS_PER_BEAT=2 unless noted):
- Continuous kernels 0..3 with tready=1 -> 8 beats on consecutive cycles. tuser on beat 0 only; tlast on beats 3 and 7. o_frame_done pulses once. Pixel order matches kernel index.
- tready toggled 1,0,0,1 pseudo-randomly -> no beat dropped or duplicated, tdata/tuser/tlast stable while stalled. Checked with a scoreboard over 3 frames.
- Second kernel withheld 5 cycles mid-line -> tvalid low for the gap and o_underrun=1. Same gap at the line boundary -> o_underrun stays 0.
- Next kernel presented exactly when beat_idx=1 loads -> o_kernel_ready=1 that cycle; beats continue with zero bubble.
- Reset asserted at beat 5 of a frame -> outputs 0 immediately. After release, the first beat carries tuser=1 and the frame completes normally.
- PIXELS_PER_BEAT=1, KERNEL_SIZE=64, IMG_WIDTH=128, IMG_HEIGHT=3 -> tlast every 128th beat, 384 beats per frame, one tuser.

Source files
------------

// File: rtl/m_axis_kernel_serializer_pkg.sv
// Shared definitions for the kernel serializer output stage.
//   statetype           : output sequencing states
//   beats_per_kernel()  : AXIS beats needed to drain one kernel
//   beats_per_line()    : AXIS beats per image line
//   cnt_width()         : counter width for a modulo-n counter, never below 1
//   params_ok()         : divisibility rules the parameter set must satisfy
package remapper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        STARVED = 2'd2,
        DRAIN   = 2'd3
    } statetype;

    function automatic int beats_per_kernel(input int kernel_size, input int pixels_per_beat);
        return kernel_size / pixels_per_beat;
    endfunction

    function automatic int beats_per_line(input int img_width, input int pixels_per_beat);
        return img_width / pixels_per_beat;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int kernel_size, input int pixels_per_beat,
                                     input int img_width, input int img_height);
        return (pixels_per_beat > 0) && (kernel_size > 0) && (img_height > 0) &&
               (kernel_size % pixels_per_beat == 0) &&
               (img_width % pixels_per_beat == 0) &&
               (img_width % kernel_size == 0);
    endfunction

endpackage

// File: rtl/m_axis_kernel_serializer_kernel_beat_buffer.sv
// One-kernel holding buffer feeding the AXIS output register.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   kernel_i         : full kernel, pixel 0 in the low bits
//   kernel_valid_i   : upstream kernel complete
//   kernel_ready_o   : kernel is captured this cycle when kernel_valid_i=1
//   out_load_i       : output register takes beat_o this cycle
//   buf_valid_o      : buffer holds beats not yet loaded
//   beat_o           : beat currently selected by the beat index
module kernel_beat_buffer
    import remapper_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int KERNEL_SIZE     = 64,
    parameter int PIXELS_PER_BEAT = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]     kernel_i,
    input  logic                                  kernel_valid_i,
    output logic                                  kernel_ready_o,
    input  logic                                  out_load_i,
    output logic                                  buf_valid_o,
    output logic [PIXELS_PER_BEAT*DATA_WIDTH-1:0] beat_o
);

    localparam int BPK    = beats_per_kernel(KERNEL_SIZE, PIXELS_PER_BEAT);
    localparam int IDX_W  = cnt_width(BPK);
    localparam int BEAT_W = PIXELS_PER_BEAT * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPK - 1);

    logic [BEAT_W-1:0] buf_q [BPK];
    logic              buf_valid_q;
    logic [IDX_W-1:0]  beat_idx_q;
    logic              last_load;
    logic              capture;

    assign last_load      = out_load_i && (beat_idx_q == LAST_IDX);
    // Ready while the final beat loads lets the next kernel stream with no bubble.
    // Gated by reset so nothing is offered while the block is held in reset.
    assign kernel_ready_o = rst_ni && (!buf_valid_q || last_load);
    assign capture        = kernel_valid_i && kernel_ready_o;
    assign buf_valid_o    = buf_valid_q;
    assign beat_o         = buf_q[beat_idx_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            beat_idx_q  <= '0;
            for (int b = 0; b < BPK; b++) begin
                buf_q[b] <= '0;
            end
        end else begin
            if (capture) begin
                for (int b = 0; b < BPK; b++) begin
                    buf_q[b] <= kernel_i[b*BEAT_W +: BEAT_W];
                end
            end
            if (out_load_i) begin
                beat_idx_q <= last_load ? '0 : beat_idx_q + 1'b1;
            end
            if (capture) begin
                buf_valid_q <= 1'b1;
            end else if (last_load) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/m_axis_kernel_serializer.sv
// Serialises remapped kernels onto an AXI4-Stream video master with
// tuser (start of frame) and tlast (end of line) framing.
//   i_clk, i_aresetn         : clock, asynchronous active-low reset
//   i_image_kernel_remapped  : kernel pixels, index 0 sent first
//   i_kernel_valid / o_kernel_ready : kernel handshake
//   m_axis_t*                : AXIS master, pixel k of a beat at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_frame_done             : one-cycle pulse after the last beat of a frame is accepted
//   o_underrun               : sticky, buffer ran dry in the middle of a line
//
// state   | meaning
// IDLE    | waiting for the first beat of a frame
// STREAM  | loading beats of the current frame
// STARVED | buffer ran empty mid-line, waiting for a kernel
// DRAIN   | last beat of the frame loaded, waiting for its handshake
module m_axis_kernel_serializer
    import remapper_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int KERNEL_SIZE     = 64,
    parameter int PIXELS_PER_BEAT = 1,
    parameter int IMG_WIDTH       = 4096,
    parameter int IMG_HEIGHT      = 3072
) (
    input  logic                                  i_clk,
    input  logic                                  i_aresetn,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]     i_image_kernel_remapped,
    input  logic                                  i_kernel_valid,
    output logic                                  o_kernel_ready,
    output logic [PIXELS_PER_BEAT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tuser,
    output logic                                  m_axis_tlast,
    output logic                                  o_frame_done,
    output logic                                  o_underrun
);

    localparam int BPL    = beats_per_line(IMG_WIDTH, PIXELS_PER_BEAT);
    localparam int X_W    = cnt_width(BPL);
    localparam int Y_W    = cnt_width(IMG_HEIGHT);
    localparam int BEAT_W = PIXELS_PER_BEAT * DATA_WIDTH;
    localparam logic [X_W-1:0] X_LAST = X_W'(BPL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    if (!params_ok(KERNEL_SIZE, PIXELS_PER_BEAT, IMG_WIDTH, IMG_HEIGHT)) begin : g_bad_params
        $error("m_axis_kernel_serializer: KERNEL_SIZE/IMG_WIDTH must be multiples of PIXELS_PER_BEAT and IMG_WIDTH of KERNEL_SIZE");
    end

    statetype          state_q, state_d;
    logic [BEAT_W-1:0] tdata_q;
    logic              tvalid_q, tuser_q, tlast_q;
    logic              frame_done_q, underrun_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;

    logic              buf_valid;
    logic [BEAT_W-1:0] beat;
    logic              out_load, handshake, line_end, frame_end, starve;

    kernel_beat_buffer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .KERNEL_SIZE     (KERNEL_SIZE),
        .PIXELS_PER_BEAT (PIXELS_PER_BEAT)
    ) u_buf (
        .clk_i          (i_clk),
        .rst_ni         (i_aresetn),
        .kernel_i       (i_image_kernel_remapped),
        .kernel_valid_i (i_kernel_valid),
        .kernel_ready_o (o_kernel_ready),
        .out_load_i     (out_load),
        .buf_valid_o    (buf_valid),
        .beat_o         (beat)
    );

    assign out_load  = buf_valid && (!tvalid_q || m_axis_tready);
    assign handshake = tvalid_q && m_axis_tready;
    assign line_end  = (x_q == X_LAST);
    assign frame_end = line_end && (y_q == Y_LAST);
    // An empty buffer at a line boundary is a normal inter-line gap, not an underrun.
    assign starve    = (state_q == STREAM) && !buf_valid && (x_q != '0);

    always_comb begin
        state_d = state_q;
        if (out_load) begin
            state_d = frame_end ? DRAIN : STREAM;
        end else begin
            case (state_q)
                STREAM:  if (starve) state_d = STARVED;
                DRAIN:   if (handshake) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q      <= IDLE;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == DRAIN) && handshake;
            if (starve) begin
                underrun_q <= 1'b1;
            end
            if (out_load) begin
                tdata_q  <= beat;
                tvalid_q <= 1'b1;
                tuser_q  <= (x_q == '0) && (y_q == '0);
                tlast_q  <= line_end;
                if (line_end) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign o_frame_done  = frame_done_q;
    assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_m_axis_kernel_serializer.sv
// Bench for m_axis_kernel_serializer: a small-image instance (8x2, 4-pixel
// kernels, 2 pixels per beat) and a wide instance (128x3, 64-pixel kernels,
// 1 pixel per beat), each checked against a queue of expected beats built
// from captured kernels and frame position arithmetic.
module tb_m_axis_kernel_serializer;

    localparam int DW   = 8;
    localparam int KS1  = 4;
    localparam int PPB1 = 2;
    localparam int W1   = 8;
    localparam int H1   = 2;
    localparam int BW1  = PPB1 * DW;
    localparam int BPK1 = KS1 / PPB1;
    localparam int BPL1 = W1 / PPB1;
    localparam int BPF1 = BPL1 * H1;
    localparam int KS2  = 64;
    localparam int W2   = 128;
    localparam int H2   = 3;
    localparam int BPF2 = W2 * H2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst1_n = 1'b0;
    logic                rst2_n = 1'b0;
    logic [KS1*DW-1:0]   kern1  = '0;
    logic                kv1    = 1'b0;
    logic                tr1    = 1'b1;
    logic                krdy1, tv1, tu1, tl1, fd1, ur1;
    logic [BW1-1:0]      td1;
    logic [KS2*DW-1:0]   kern2  = '0;
    logic                kv2    = 1'b0;
    logic                tr2    = 1'b1;
    logic                krdy2, tv2, tu2, tl2, fd2, ur2;
    logic [DW-1:0]       td2;

    m_axis_kernel_serializer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS1), .PIXELS_PER_BEAT(PPB1),
        .IMG_WIDTH(W1), .IMG_HEIGHT(H1)
    ) dut1 (
        .i_clk(clk), .i_aresetn(rst1_n),
        .i_image_kernel_remapped(kern1), .i_kernel_valid(kv1), .o_kernel_ready(krdy1),
        .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(tr1),
        .m_axis_tuser(tu1), .m_axis_tlast(tl1),
        .o_frame_done(fd1), .o_underrun(ur1)
    );

    m_axis_kernel_serializer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS2), .PIXELS_PER_BEAT(1),
        .IMG_WIDTH(W2), .IMG_HEIGHT(H2)
    ) dut2 (
        .i_clk(clk), .i_aresetn(rst2_n),
        .i_image_kernel_remapped(kern2), .i_kernel_valid(kv2), .o_kernel_ready(krdy2),
        .m_axis_tdata(td2), .m_axis_tvalid(tv2), .m_axis_tready(tr2),
        .m_axis_tuser(tu2), .m_axis_tlast(tl2),
        .o_frame_done(fd2), .o_underrun(ur2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus: kernel data is re-randomised every cycle; only the handshake
    // cycle matters. Kernels are offered until the sent count reaches target.
    int target1 = 0, sent1 = 0, target2 = 0, sent2 = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        kern1 = $urandom;
        kv1   = (sent1 < target1);
        tr1   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < KS2*DW/32; i++) kern2[i*32 +: 32] = $urandom;
        kv2   = (sent2 < target2);
    end

    // Reference model for dut1: expected beat queue plus frame position.
    logic [BW1-1:0]  exp_q1 [$];
    int              beats1 = 0, fdc1 = 0, cyc1 = 0;
    int              first_cap1 = -1, first_val1 = -1, last_acc1 = -1;
    bit              stall1 = 1'b0;
    logic [BW1+1:0]  held1 = '0;

    always @(negedge clk) begin
        if (!rst1_n) begin
            exp_q1.delete();
            beats1 = 0; cyc1 = 0; stall1 = 1'b0;
            first_cap1 = -1; first_val1 = -1; last_acc1 = -1;
        end else begin
            cyc1++;
            if (kv1 && krdy1) begin
                sent1++;
                if (first_cap1 < 0) first_cap1 = cyc1;
                for (int b = 0; b < BPK1; b++) exp_q1.push_back(kern1[b*BW1 +: BW1]);
            end
            if (stall1) check_val("stall_hold", {tv1, tu1, tl1, td1}, {1'b1, held1});
            if (tv1 && first_val1 < 0) first_val1 = cyc1;
            if (tv1 && tr1) begin
                check_val("sb1_nonempty", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0)
                    check_val("beat1", {tu1, tl1, td1},
                              {beats1 % BPF1 == 0, beats1 % BPL1 == BPL1 - 1, exp_q1.pop_front()});
                beats1++;
                last_acc1 = cyc1;
            end
            stall1 = tv1 && !tr1;
            held1  = {tu1, tl1, td1};
            if (fd1) fdc1++;
        end
    end

    // Reference model for dut2 (one pixel per beat).
    logic [DW-1:0] exp_q2 [$];
    int            beats2 = 0, fdc2 = 0, tlc2 = 0, tuc2 = 0;

    always @(negedge clk) begin
        if (rst2_n) begin
            if (kv2 && krdy2) begin
                sent2++;
                for (int p = 0; p < KS2; p++) exp_q2.push_back(kern2[p*DW +: DW]);
            end
            if (tv2 && tr2) begin
                check_val("sb2_nonempty", exp_q2.size() != 0, 1);
                if (exp_q2.size() != 0)
                    check_val("beat2", {tu2, tl2, td2},
                              {beats2 % BPF2 == 0, beats2 % W2 == W2 - 1, exp_q2.pop_front()});
                if (tl2) tlc2++;
                if (tu2) tuc2++;
                beats2++;
            end
            if (fd2) fdc2++;
        end
    end

    task automatic wait_fd1(input int n, input int limit);
        int k = 0;
        while (fdc1 < n && k < limit) begin @(posedge clk); k++; end
        check_val("frame_done_wait", fdc1, n);
    endtask

    task automatic wait_beats1(input int n, input int limit);
        int k = 0;
        while (beats1 < n && k < limit) begin @(posedge clk); k++; end
        check_val("beats_wait", beats1, n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_tvalid", tv1, 0);
        check_val("rst_tuser",  tu1, 0);
        check_val("rst_tlast",  tl1, 0);
        check_val("rst_fdone",  fd1, 0);
        check_val("rst_underrun", ur1, 0);
        check_val("rst_kready", krdy1, 0);
        rst1_n  = 1'b1;
        rst2_n  = 1'b1;
        target2 = 6;

        // Four back-to-back kernels, tready held high: one full frame.
        target1 = 4;
        wait_fd1(1, 60);
        repeat (3) @(posedge clk);
        #2;
        check_val("t1_beats", beats1, 8);
        check_val("t1_latency", first_val1 - first_cap1, 2);
        check_val("t1_no_bubble", last_acc1 - first_val1, 7);
        check_val("t1_single_pulse", fdc1, 1);
        check_val("t1_idle_tvalid", tv1, 0);
        check_val("t1_underrun", ur1, 0);
        check_val("t1_sb_empty", exp_q1.size(), 0);

        // Random backpressure over three frames.
        rand_ready = 1'b1;
        target1 = 16;
        wait_fd1(4, 800);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_val("t2_beats", beats1, 32);
        check_val("t2_sb_empty", exp_q1.size(), 0);
        check_val("t2_underrun", ur1, 0);

        // Gap at a line boundary: no underrun.
        target1 = 18;
        wait_beats1(36, 100);
        repeat (6) @(posedge clk);
        #2;
        check_val("line_gap_tvalid", tv1, 0);
        check_val("line_gap_underrun", ur1, 0);
        target1 = 20;
        wait_fd1(5, 100);
        check_val("line_gap_frame_underrun", ur1, 0);

        // Gap in the middle of a line: underrun, sticky.
        target1 = 21;
        wait_beats1(42, 100);
        repeat (5) @(posedge clk);
        #2;
        check_val("midline_gap_tvalid", tv1, 0);
        check_val("midline_underrun", ur1, 1);
        target1 = 24;
        wait_fd1(6, 100);
        repeat (2) @(posedge clk);
        #2;
        check_val("underrun_sticky", ur1, 1);
        check_val("t3_beats", beats1, 48);
        check_val("t3_sb_empty", exp_q1.size(), 0);

        // Wide instance: one 384-beat frame.
        begin
            int k = 0;
            while (fdc2 < 1 && k < 1500) begin @(posedge clk); k++; end
        end
        repeat (3) @(posedge clk);
        #2;
        check_val("w_frame_done", fdc2, 1);
        check_val("w_beats", beats2, 384);
        check_val("w_tlast_count", tlc2, 3);
        check_val("w_tuser_count", tuc2, 1);
        check_val("w_underrun", ur2, 0);
        check_val("w_sb_empty", exp_q2.size(), 0);

        // Reset in the middle of a frame, then a clean frame.
        target1 = 28;
        wait_beats1(53, 60);
        #2;
        rst1_n = 1'b0;
        #1;
        check_val("mid_rst_tvalid", tv1, 0);
        check_val("mid_rst_tuser", tu1, 0);
        check_val("mid_rst_tlast", tl1, 0);
        check_val("mid_rst_underrun", ur1, 0);
        check_val("mid_rst_kready", krdy1, 0);
        repeat (3) @(posedge clk);
        #2;
        rst1_n  = 1'b1;
        target1 = sent1 + 4;
        wait_fd1(7, 60);
        repeat (3) @(posedge clk);
        #2;
        check_val("post_rst_beats", beats1, 8);
        check_val("post_rst_tvalid", tv1, 0);
        check_val("post_rst_underrun", ur1, 0);
        check_val("post_rst_sb_empty", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
